// File: rtl/mini_alu_pipe_pkg.sv
// Shared definitions for the two-stage mini ALU pipeline: opcodes, flag
// positions and the default datapath width.
package mini_alu_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SHL   = 3'd5,
    OP_SHR   = 3'd6,
    OP_PASSB = 3'd7
  } alu_op_e;

  // Flag vector layout is {N,V,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  function automatic logic [7:0] op_onehot(input alu_op_e op);
    return 8'b1 << op;
  endfunction

endpackage

// File: rtl/mini_alu_core.sv
// Stateless ALU datapath: result and {N,V,C,Z} flags from two operands.
module mini_alu_core
  import mini_alu_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  logic [SW-1:0]  sh;
  logic [WIDTH:0] add_w, sub_w, shl_w, shr_w;
  logic [M:0]     res;
  logic           c, v;

  assign sh    = b_i[SW-1:0];
  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  // One guard bit on each side catches the last bit shifted out; it is 0
  // for a zero shift and for shifts wider than the operand.
  assign shl_w = {1'b0, a_i} << sh;
  assign shr_w = {a_i, 1'b0} >> sh;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res = add_w[M:0];
        c   = add_w[WIDTH];
        v   = (a_i[M] == b_i[M]) && (res[M] != a_i[M]);
      end
      OP_SUB: begin
        res = sub_w[M:0];
        c   = ~sub_w[WIDTH];
        v   = (a_i[M] != b_i[M]) && (res[M] != a_i[M]);
      end
      OP_AND:   res = a_i & b_i;
      OP_OR:    res = a_i | b_i;
      OP_XOR:   res = a_i ^ b_i;
      OP_SHL: begin
        res = shl_w[M:0];
        c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res = shr_w[WIDTH:1];
        c   = shr_w[0];
      end
      OP_PASSB: res = b_i;
      default:  res = '0;
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_N] = res[M];
    flags_o[FLAG_V] = v;
    flags_o[FLAG_C] = c;
    flags_o[FLAG_Z] = (res == '0);
  end

  assign result_o = res;

endmodule

// File: rtl/mini_alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 registers the request, S2 computes
// and registers result/flags. Optional accumulator can replace operand a.
module mini_alu_pipe
  import mini_alu_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             use_acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [7:0]       led
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_e          op;
    logic             use_acc;
  } req_t;

  logic [2:1]       vld_pipe_q, vld_pipe_d;
  req_t             s1_q, s1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic [7:0]       led_q, led_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             out_fire, s2_load, in_fire, acc_sel;
  logic [WIDTH-1:0] core_a, core_res;
  logic [3:0]       core_flags;

  assign out_fire = vld_pipe_q[2] & out_ready;
  assign s2_load  = vld_pipe_q[1] & (~vld_pipe_q[2] | out_ready);
  assign in_ready = ~vld_pipe_q[1] | s2_load;
  assign in_fire  = in_valid & in_ready;

  // Accumulator is read at the S2 load edge, so a chained request sees the
  // value written by its predecessor one edge earlier.
  assign acc_sel = (ACC_EN != 0) && s1_q.use_acc;
  assign core_a  = acc_sel ? acc_q : s1_q.a;

  mini_alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (core_a),
    .b_i      (s1_q.b),
    .op_i     (s1_q.op),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    res_d      = res_q;
    flags_d    = flags_q;
    led_d      = led_q;
    acc_d      = acc_q;

    if (in_fire) begin
      vld_pipe_d[1] = 1'b1;
      s1_d.a        = in_a;
      s1_d.b        = in_b;
      s1_d.op       = alu_op_e'(in_op);
      s1_d.use_acc  = use_acc;
    end else if (s2_load) begin
      vld_pipe_d[1] = 1'b0;
    end

    if (s2_load) begin
      vld_pipe_d[2] = 1'b1;
      res_d         = core_res;
      flags_d       = core_flags;
      led_d         = op_onehot(s1_q.op);
    end else if (out_fire) begin
      vld_pipe_d[2] = 1'b0;
      led_d         = '0;
    end

    // Clear beats a same-edge accumulate load
    if ((ACC_EN == 0) || clr_acc)
      acc_d = '0;
    else if (s2_load && acc_sel)
      acc_d = core_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      led_q      <= '0;
      acc_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      led_q      <= led_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid  = vld_pipe_q[2];
  assign out_result = res_q;
  assign out_flags  = flags_q;
  assign led        = led_q;

endmodule

// File: tb/tb_mini_alu_pipe.sv
// Scoreboard bench for mini_alu_pipe (WIDTH=8): expected results are queued
// at input transfer and compared when the pipe emits them.
module tb_mini_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [2:0] in_op = '0;
  logic       use_acc = 1'b0, clr_acc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] led;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    logic [7:0] l;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   model_acc = 0;
  int   accepted = 0;

  always #5 clk = ~clk;

  mini_alu_pipe #(.WIDTH(8), .ACC_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .use_acc    (use_acc),
    .clr_acc    (clr_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .led        (led)
  );

  // Reference model written with plain integer arithmetic
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t m;
    int r = 0, c = 0, v = 0, s, sa, sb, sh;
    sh = b % 8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin s = a + b; r = s % 256; c = (s > 255) ? 1 : 0;
               s = sa + sb; v = (s > 127 || s < -128) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0;
               s = sa - sb; v = (s > 127 || s < -128) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << sh) % 256; c = (sh != 0) ? ((a >> (8 - sh)) & 1) : 0; end
      6: begin r = a >> sh; c = (sh != 0) ? ((a >> (sh - 1)) & 1) : 0; end
      default: r = b;
    endcase
    m.r    = r[7:0];
    m.f[3] = (r >= 128);
    m.f[2] = (v != 0);
    m.f[1] = (c != 0);
    m.f[0] = (r == 0);
    m.l    = 8'd1 << op;
    return m;
  endfunction

  task automatic send(input int op, input int a, input int b, input bit ua);
    exp_t e;
    int t = 0;
    in_valid = 1'b1;
    in_op    = op[2:0];
    in_a     = a[7:0];
    in_b     = b[7:0];
    use_acc  = ua;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end else begin
      e = model(op, ua ? model_acc : a, b);
      if (ua) model_acc = e.r;
      sbq.push_back(e);
      accepted++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    use_acc  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", name, sbq.size());
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard consumer: every output transfer must match the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output result=%h required=none", out_result);
      end else begin
        mon_e = sbq.pop_front();
        checks += 3;
        if (out_result !== mon_e.r) begin
          errors++;
          $display("FAIL sb_result got=%h exp=%h", out_result, mon_e.r);
        end
        if (out_flags !== mon_e.f) begin
          errors++;
          $display("FAIL sb_flags got=%b exp=%b", out_flags, mon_e.f);
        end
        if (led !== mon_e.l) begin
          errors++;
          $display("FAIL sb_led got=%h exp=%h", led, mon_e.l);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, out_result, out_flags, led} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0", {out_valid, out_result, out_flags, led});
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_add_wrap();
    out_ready = 1'b1;
    send(0, 8'hFF, 8'h01, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_early_valid got=%b exp=0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_result, out_flags, led} !== {1'b1, 8'h00, 4'b0011, 8'h01}) begin
      errors++;
      $display("FAIL add_wrap got=%b_%h_%b_%h exp=1_00_0011_01", out_valid, out_result, out_flags, led);
    end
    drain("add_wrap");
  endtask

  task automatic test_sub_shl();
    send(1, 8'h80, 8'h01, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({out_result, out_flags} !== {8'h7F, 4'b0110}) begin
      errors++;
      $display("FAIL sub_ovf got=%h_%b exp=7f_0110", out_result, out_flags);
    end
    drain("sub");
    send(5, 8'h81, 8'h01, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({out_result, out_flags[1]} !== {8'h02, 1'b1}) begin
      errors++;
      $display("FAIL shl_carry got=%h_%b exp=02_1", out_result, out_flags[1]);
    end
    drain("shl");
    send(6, 8'h81, 8'h01, 1'b0);
    send(5, 8'h81, 8'h00, 1'b0);
    send(1, 8'h01, 8'h02, 1'b0);
    send(0, 8'h7F, 8'h01, 1'b0);
    send(6, 8'h80, 8'h0F, 1'b0);
    send(7, 8'h12, 8'h00, 1'b0);
    drain("edges");
  endtask

  task automatic test_random_ops();
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, l0;
    logic [3:0] f0;
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        send(0, 8'h10, 8'h01, 1'b0);
        send(1, 8'h20, 8'h02, 1'b0);
        send(4, 8'h3C, 8'h0F, 1'b0);
        send(3, 8'h40, 8'h04, 1'b0);
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        checks++;
        if (accepted !== 2) begin
          errors++;
          $display("FAIL bp_accepted got=%0d exp=2", accepted);
        end
        r0 = out_result; f0 = out_flags; l0 = led;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if ({in_ready, out_valid, out_result, out_flags, led} !== {1'b0, 1'b1, 8'h11, 4'b0000, 8'h01}) begin
            errors++;
            $display("FAIL bp_stall cyc=%0d got=%b_%b_%h_%b_%h exp=0_1_11_0000_01",
                     k, in_ready, out_valid, out_result, out_flags, led);
          end
          checks++;
          if ({out_result, out_flags, led} !== {r0, f0, l0}) begin
            errors++;
            $display("FAIL bp_stable cyc=%0d got=%h exp=%h", k, out_result, r0);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("back_to_back");
  endtask

  task automatic test_accumulate();
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc   = 1'b0;
    model_acc = 0;
    send(0, 8'hAA, 8'd5, 1'b1);
    send(0, 8'h55, 8'd5, 1'b1);
    send(0, 8'hAA, 8'd5, 1'b1);
    drain("acc_chain");
    checks++;
    if (model_acc != 15) begin
      errors++;
      $display("FAIL acc_model got=%0d exp=15", model_acc);
    end
    send(0, 8'h00, 8'd0, 1'b1);
    drain("acc_readback");
  endtask

  task automatic test_clr_collision();
    send(0, 8'h00, 8'd7, 1'b1);
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc   = 1'b0;
    model_acc = 0;
    drain("clr_collide");
    send(0, 8'h33, 8'd0, 1'b1);
    drain("clr_readback");
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    send(0, 8'h01, 8'h01, 1'b0);
    send(0, 8'h02, 8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, led} !== 9'd0) begin
      errors++;
      $display("FAIL rst_async got=%b_%h exp=0_00", out_valid, led);
    end
    sbq.delete();
    model_acc = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_stale got=%0d exp=0", seen);
    end
    @(posedge clk); #1;
    send(0, 8'h00, 8'd9, 1'b1);
    send(0, 8'h00, 8'd9, 1'b1);
    drain("rst_recover");
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_shl();
    test_random_ops();
    test_back_to_back();
    test_accumulate();
    test_clr_collision();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
